// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and default frame constants shared by the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for asynchronous inputs, resetting to 1 (idle line).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b11;
    else     {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver, LSB first, with a one-cycle valid pulse and framing-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic rx_s, rx_s_prev, valid_n, ferr_n;
  uart_sync2 u_sync (.clk(clk), .rst(rst), .d(rx_serial), .q(rx_s));
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      rx_s_prev   <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      data_out    <= data_n;
      rx_valid    <= valid_n;
      framing_err <= ferr_n;
      rx_s_prev   <= rx_s;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: if (rx_s_prev && !rx_s) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (os_tick) begin
        if (cnt == HALF) begin
          state_n = rx_s ? IDLE : DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      DATA: if (os_tick) begin
        if (cnt == LAST) begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_n   = '0;
          idx_n   = idx + 1'b1;
          state_n = idx == LAST_BIT ? STOP : DATA;
        end else cnt_n = cnt + 1'b1;
      end
      STOP: if (os_tick) begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          data_n  = rx_s ? shreg : data_out;
          valid_n = rx_s;
          ferr_n  = !rx_s;
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end else cnt_n = cnt + 1'b1;
      end
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences, checked by a pulse scoreboard.
module tb_uart_rx;
  logic clk = 0, rst = 1, os_tick = 0, rx_serial = 1;
  logic [7:0] data_out;
  logic rx_valid, framing_err, rx_busy;
  int checks = 0, errors = 0;
  int div = 4;
  logic [7:0] last_good = 8'h00;
  logic prev_valid = 0, prev_ferr = 0;
  typedef struct { logic err; logic [7:0] data; } exp_t;
  exp_t q[$];
  typedef struct { int div; logic [7:0] data; } vec_t;
  vec_t vecs[4];

  uart_rx dut (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_serial(rx_serial),
    .data_out(data_out), .rx_valid(rx_valid), .framing_err(framing_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    int t = 0;
    forever begin
      @(negedge clk);
      t = (t + 1 >= div) ? 0 : t + 1;
      os_tick = (t == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_valid || framing_err)) begin
      chk("exclusive", {31'd0, rx_valid & framing_err}, 0);
      chk("pulse_width", {31'd0, rx_valid ? prev_valid : prev_ferr}, 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%0h, required no pulse", rx_valid, framing_err, data_out);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {31'd0, framing_err}, {31'd0, e.err});
        chk("pulse_data", {24'd0, data_out}, {24'd0, e.data});
      end
    end
    prev_valid = rx_valid;
    prev_ferr  = framing_err;
  end

  task automatic send_bit(input logic b, input int n);
    rx_serial = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    int bc = 16 * div;
    exp_t e;
    e.err  = !stop;
    e.data = stop ? d : last_good;
    q.push_back(e);
    if (stop) last_good = d;
    send_bit(0, bc);
    for (int i = 0; i < 8; i++) send_bit(d[i], bc);
    send_bit(stop, bc);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses missing, required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4, 8'hA5};
    vecs[1] = '{1, 8'h55};
    vecs[2] = '{4, 8'h01};
    vecs[3] = '{4, 8'h80};
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_ferr", {31'd0, framing_err}, 0);
    chk("rst_busy", {31'd0, rx_busy}, 0);
    rst = 0;
    repeat (20) @(negedge clk);

    foreach (vecs[i]) begin
      div = vecs[i].div;
      repeat (8) @(negedge clk);
      send_frame(vecs[i].data, 1);
      send_bit(1, 16 * div);
      drain("frame_drain");
      chk("frame_data", {24'd0, data_out}, {24'd0, vecs[i].data});
      chk("frame_idle", {31'd0, rx_busy}, 0);
    end

    div = 4;
    repeat (8) @(negedge clk);
    rx_serial = 0;
    repeat (3 * 4) @(negedge clk);
    chk("glitch_busy", {31'd0, rx_busy}, 1);
    repeat (2 * 4) @(negedge clk);
    rx_serial = 1;
    repeat (30 * 4) @(negedge clk);
    chk("glitch_idle", {31'd0, rx_busy}, 0);
    chk("glitch_data", {24'd0, data_out}, {24'd0, last_good});

    send_frame(8'h3C, 0);
    send_bit(0, 24 * 4);
    chk("break_busy", {31'd0, rx_busy}, 1);
    rx_serial = 1;
    repeat (8) @(negedge clk);
    chk("break_idle", {31'd0, rx_busy}, 0);
    drain("ferr_drain");
    chk("ferr_data", {24'd0, data_out}, {24'd0, last_good});
    repeat (64) @(negedge clk);

    send_frame(8'h00, 1);
    send_frame(8'hFF, 1);
    send_bit(1, 64);
    drain("b2b_drain");
    chk("b2b_data", {24'd0, data_out}, 32'hFF);

    send_bit(0, 64);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i), 64);
    rx_serial = 1'b0;
    repeat (32) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midrst_data", {24'd0, data_out}, 0);
    chk("midrst_valid", {31'd0, rx_valid}, 0);
    chk("midrst_ferr", {31'd0, framing_err}, 0);
    chk("midrst_busy", {31'd0, rx_busy}, 0);
    rx_serial = 1;
    repeat (10) @(negedge clk);
    rst = 0;
    last_good = 8'h00;
    repeat (256) @(negedge clk);
    chk("postrst_idle", {31'd0, rx_busy}, 0);
    send_frame(8'h7E, 1);
    send_bit(1, 64);
    drain("postrst_drain");
    chk("postrst_data", {24'd0, data_out}, 32'h7E);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
